ram_bist: RTL and testbench
===========================

# ram_bist

Built-in self-test initiator for the single-port `ram` block: it drives the RAM's `cen`/`wen`/`addr`/`din` pins and checks `dout`. On `start` it runs two passes with no host involvement:
- a write pass that fills addresses `0..LAST_ADDR` with a deterministic pattern;
- a read pass over the same addresses that compares each returned word and accumulates errors.

It sits between the test/control logic and the RAM instance. It is the initiator end of the RAM port; the RAM is the responder.

## Interface
Parameters
- `AW`, 8: RAM address width.
- `DW`, 32: RAM data width.
- `LAST_ADDR`, 8'h1f: highest address tested. Word count N = LAST_ADDR+1.

Ports (clock and reset first)
- `clk`, in, 1: single clock, rising edge.
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: begin test. Sampled only in IDLE.
- `invert`, in, 1: pattern select. Captured with `start`.
- `busy`, out, 1: test in progress.
- `done`, out, 1: one-cycle completion pulse.
- `pass`, out, 1: result of the last completed test, with err_cnt==0.
- `err_cnt`, out, 8: mismatch count, saturating at 255.
- `fail_addr`, out, AW: first mismatching address.
- `ram_cen`, out, 1: RAM enable, active-high.
- `ram_wen`, out, 1: RAM write enable. 1 = write, 0 = read.
- `ram_addr`, out, AW: RAM address.
- `ram_din`, out, DW: RAM write data.
- `ram_dout`, in, DW: RAM read data.

## Operation
RAM contract:
- At a rising edge with cen=1 and wen=1, the RAM writes `din` to `mem[addr]`.
- At a rising edge with cen=1 and wen=0, the RAM loads `mem[addr]` into `dout`. Read latency is 1 edge.

Pattern: `pat(a)` = zero-extend(a) to DW, XOR `{DW{inv_q}}`. `inv_q` is `invert` latched when `start` is accepted.

FSM states:
- IDLE:
  - `start`=1 → WRITE. In the same edge, clear `err_cnt`, `fail_addr` and `pass`.
- WRITE:
  - Drives cen=1, wen=1, addr=ptr, din=pat(ptr).
  - `ptr` increments each cycle.
  - At ptr==LAST_ADDR → READ, with ptr=0.
- READ:
  - Drives cen=1, wen=0, addr=ptr.
  - A compare tag (valid, addr) is pipelined one cycle.
  - At ptr==LAST_ADDR → DRAIN.
- DRAIN:
  - Drives cen=0, so the last outstanding compare completes.
  - → DONE.
- DONE:
  - `done`=1 for one cycle; `pass` = (err_cnt==0).
  - → IDLE.

Compare rules:
- Compare runs when the tag valid bit is set: `ram_dout` against pat(tag addr).
- On mismatch, `err_cnt` increments, saturating at 255.
- `fail_addr` is loaded only on the first mismatch of a test.

Other rules:
- `start` is ignored outside IDLE.
- `invert` changes mid-test have no effect.
- `ram_din` is 0 whenever wen=0.
- `ram_addr` is 0 in IDLE and DONE.

## Timing
- All outputs are registered.
- Reset values: busy=0, done=0, pass=0, err_cnt=0, fail_addr=0, ram_cen=0, ram_wen=0, ram_addr=0, ram_din=0; state=IDLE.
- Let E0 be the edge that samples `start`=1 in IDLE. E0 drives the first write command.
- Writes commit at edges E1..EN.
- Reads issue at edges EN+1..E2N. Their compares happen at edges EN+2..E2N+1.
- Edge E2N+1 sets `done`=1 and drops `busy`. For N=32, `done` is high in the cycle after E65.
- `busy` is 1 from E0 to E2N+1.
- Back-to-back: `start` held high re-launches at the edge after the `done` cycle.
- `reset_n` low at any time, mid-pass included, forces every output and the FSM to reset values immediately. No RAM access is issued after that.
- err_cnt saturation: at 255, further mismatches leave it at 255. `pass` stays 0.

## Structure
- Package `ram_pkg`:
  - AW/DW defaults;
  - the FSM state typedef (IDLE, WRITE, READ, DRAIN, DONE);
  - the `pat` function.
- One sub-module, `ram_bist_cmp`: compare tag pipeline, mismatch detect, saturating counter, first-fail capture.
- The FSM and address pointer stay in the top module.

## Test plan
- Reset, then start with invert=0 against a `ram` instance, N=32:
  - mem[a]=a for all a;
  - done after 65 edges;
  - pass=1, err_cnt=0.
- Start with invert=1: mem[5]=32'hFFFF_FFFA; pass=1.
- Bench forces `ram_dout` bit 0 flipped when reading addresses 3 and 7: err_cnt=2, fail_addr=3, pass=0.
- Bench forces all read data to 0 with LAST_ADDR=8'hFF and invert=1: err_cnt=255, saturated, not 256; fail_addr=0.
- reset_n pulsed low in the middle of the read pass: outputs return to reset values; ram_cen=0 in the same cycle. A new start then gives pass=1.
- start asserted while busy: ignored. Exactly one `done` pulse; no change to ptr sequencing.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared definitions for the RAM built-in self-test.
// Holds the default RAM geometry, the BIST FSM state type and the
// address-derived test pattern used by both the writer and the checker.
package ram_pkg;

  localparam int unsigned RamAw = 8;
  localparam int unsigned RamDw = 32;

  // Width the pattern is computed at; callers slice down to their DW.
  localparam int unsigned PatW = 64;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StDrain,
    StDone
  } state_e;

  // Zero-extended address, optionally inverted across the full word.
  function automatic logic [PatW-1:0] pat(logic [PatW-1:0] addr, logic inv);
    return addr ^ {PatW{inv}};
  endfunction

endpackage

// File: rtl/ram_bist_cmp.sv
// Read-data checker for the RAM BIST.
// A read issued at one edge returns its data on rd_data one cycle later, so
// the issuing address is carried in a one-stage tag and compared then.
// Ports:
//   clk, reset_n      clock, async active-low reset
//   clr               clears the error state at test start
//   issue, issue_addr a read is being issued to the RAM at this edge
//   inv               pattern inversion for the running test
//   rd_data           RAM read data
//   err_cnt           mismatch count, saturating at 255
//   fail_addr         address of the first mismatch in the test
//   clean_next        error count after this edge will still be zero
module ram_bist_cmp
  import ram_pkg::*;
#(
  parameter int unsigned AW = RamAw,
  parameter int unsigned DW = RamDw
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          issue,
  input  logic [AW-1:0] issue_addr,
  input  logic          inv,
  input  logic [DW-1:0] rd_data,
  output logic [7:0]    err_cnt,
  output logic [AW-1:0] fail_addr,
  output logic          clean_next
);

  logic          tag_vld_q;
  logic [AW-1:0] tag_addr_q;
  logic [7:0]    err_q, err_d;
  logic [AW-1:0] fail_q, fail_d;
  logic [PatW-1:0] exp_w;
  logic          mismatch;

  always_comb begin
    exp_w    = pat(PatW'(tag_addr_q), inv);
    mismatch = tag_vld_q && (rd_data != exp_w[DW-1:0]);
    err_d    = err_q;
    fail_d   = fail_q;
    if (clr) begin
      err_d  = '0;
      fail_d = '0;
    end else if (mismatch) begin
      // A zero count means no earlier mismatch in this test.
      if (err_q == 8'd0) fail_d = tag_addr_q;
      if (err_q != 8'hff) err_d = err_q + 8'd1;
    end
    clean_next = (err_d == 8'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_vld_q  <= 1'b0;
      tag_addr_q <= '0;
      err_q      <= '0;
      fail_q     <= '0;
    end else begin
      tag_vld_q  <= issue;
      tag_addr_q <= issue_addr;
      err_q      <= err_d;
      fail_q     <= fail_d;
    end
  end

  assign err_cnt   = err_q;
  assign fail_addr = fail_q;

endmodule

// File: rtl/ram_bist.sv
// Built-in self-test initiator for a single-port RAM.
// On start it writes pat(a) to every address 0..LAST_ADDR, reads them back,
// and reports mismatches. All outputs are registered.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   start, invert         launch a test (IDLE only); pattern select
//   busy, done, pass      status; done is a one-cycle completion pulse
//   err_cnt, fail_addr    mismatch count (saturating) and first failing address
//   ram_cen/wen/addr/din  RAM command port (wen=1 write, wen=0 read)
//   ram_dout              RAM read data, one edge after the read command
module ram_bist
  import ram_pkg::*;
#(
  parameter int unsigned    AW        = RamAw,
  parameter int unsigned    DW        = RamDw,
  parameter logic [AW-1:0]  LAST_ADDR = 'h1f
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          invert,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [7:0]    err_cnt,
  output logic [AW-1:0] fail_addr,
  output logic          ram_cen,
  output logic          ram_wen,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          inv_q, inv_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic          cen_q, cen_d;
  logic          wen_q, wen_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic          clr;
  logic          clean_next;
  logic [AW-1:0] ptr_inc;
  logic [PatW-1:0] pat_w;

  assign ptr_inc = ptr_q + AW'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    inv_d   = inv_q;
    pass_d  = pass_q;
    cen_d   = 1'b0;
    wen_d   = 1'b0;
    addr_d  = '0;
    din_d   = '0;
    clr     = 1'b0;
    pat_w   = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          clr     = 1'b1;
          pass_d  = 1'b0;
          inv_d   = invert;
          ptr_d   = '0;
          state_d = StWrite;
          pat_w   = pat('0, invert);
          cen_d   = 1'b1;
          wen_d   = 1'b1;
          din_d   = pat_w[DW-1:0];
        end
      end
      StWrite: begin
        cen_d = 1'b1;
        if (ptr_q == LAST_ADDR) begin
          // Last write is committing now; first read goes out next edge.
          state_d = StRead;
          ptr_d   = '0;
        end else begin
          ptr_d  = ptr_inc;
          pat_w  = pat(PatW'(ptr_inc), inv_q);
          wen_d  = 1'b1;
          addr_d = ptr_inc;
          din_d  = pat_w[DW-1:0];
        end
      end
      StRead: begin
        if (ptr_q == LAST_ADDR) begin
          state_d = StDrain;
        end else begin
          ptr_d  = ptr_inc;
          cen_d  = 1'b1;
          addr_d = ptr_inc;
        end
      end
      StDrain: begin
        // Final compare lands at this edge; fold it into pass.
        state_d = StDone;
        pass_d  = clean_next;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d == StWrite) || (state_d == StRead) || (state_d == StDrain);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      inv_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      cen_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      inv_q   <= inv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      cen_q   <= cen_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  ram_bist_cmp #(
    .AW (AW),
    .DW (DW)
  ) u_cmp (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr        (clr),
    .issue      (state_q == StRead),
    .issue_addr (ptr_q),
    .inv        (inv_q),
    .rd_data    (ram_dout),
    .err_cnt    (err_cnt),
    .fail_addr  (fail_addr),
    .clean_next (clean_next)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign ram_cen  = cen_q;
  assign ram_wen  = wen_q;
  assign ram_addr = addr_q;
  assign ram_din  = din_q;

endmodule

// File: tb/tb_ram_bist.sv
module tb_ram_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, invert;
  logic start_a, start_b;

  // DUT a: N=32 against a behavioural RAM with optional bit-0 corruption.
  logic        a_busy, a_done, a_pass, a_cen, a_wen;
  logic [7:0]  a_err, a_faddr, a_addr;
  logic [31:0] a_din, a_dout;

  // DUT b: N=256 with read data stuck at zero.
  logic        b_busy, b_done, b_pass, b_cen, b_wen;
  logic [7:0]  b_err, b_faddr, b_addr;
  logic [31:0] b_din;

  ram_bist u_dut_a (
    .clk (clk), .reset_n (reset_n), .start (start_a), .invert (invert),
    .busy (a_busy), .done (a_done), .pass (a_pass), .err_cnt (a_err), .fail_addr (a_faddr),
    .ram_cen (a_cen), .ram_wen (a_wen), .ram_addr (a_addr), .ram_din (a_din),
    .ram_dout (a_dout)
  );

  ram_bist #(.AW (8), .DW (32), .LAST_ADDR (8'hff)) u_dut_b (
    .clk (clk), .reset_n (reset_n), .start (start_b), .invert (invert),
    .busy (b_busy), .done (b_done), .pass (b_pass), .err_cnt (b_err), .fail_addr (b_faddr),
    .ram_cen (b_cen), .ram_wen (b_wen), .ram_addr (b_addr), .ram_din (b_din),
    .ram_dout (32'h0)
  );

  // Behavioural single-port RAM, 1-edge read latency.
  logic [31:0] mem [0:255];
  logic [31:0] rd_q;
  logic [7:0]  rd_addr_q;
  logic        flip_en;

  always @(posedge clk) begin
    if (a_cen) begin
      if (a_wen) mem[a_addr] <= a_din;
      else begin
        rd_q      <= mem[a_addr];
        rd_addr_q <= a_addr;
      end
    end
  end

  assign a_dout = rd_q ^ {31'h0, flip_en && (rd_addr_q == 8'd3 || rd_addr_q == 8'd7)};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0] err;
    logic [7:0] faddr;
    logic       pass;
  } exp_t;

  exp_t sbq[$];

  logic inv_exp;
  int   wr_cnt, rd_cnt, done_cnt_a;

  // Scoreboard pop on completion, plus command-port protocol checks for DUT a.
  always @(negedge clk) begin
    exp_t e;
    if (a_done || b_done) begin
      if (a_done) done_cnt_a++;
      if (sbq.size() == 0) begin
        chk("sb_pending", 32'(sbq.size()), 32'd1);
      end else begin
        e = sbq.pop_front();
        chk("err_cnt",   32'(a_done ? a_err : b_err),     32'(e.err));
        chk("fail_addr", 32'(a_done ? a_faddr : b_faddr), 32'(e.faddr));
        chk("pass",      32'(a_done ? a_pass : b_pass),   32'(e.pass));
        chk("busy_at_done", 32'(a_done ? a_busy : b_busy), 32'd0);
      end
    end
    if (a_cen) begin
      if (a_wen) wr_cnt++;
      else rd_cnt++;
      chk("din", a_din, a_wen ? ({24'h0, a_addr} ^ {32{inv_exp}}) : 32'h0);
    end
    if (!a_busy) begin
      chk("idle_addr", 32'(a_addr), 32'd0);
      chk("idle_cen", 32'(a_cen), 32'd0);
    end
  end

  task automatic run_a(input logic inv, input logic flip, input logic poke, input exp_t e);
    int cyc;
    int d0;
    logic got;
    inv_exp = inv;
    flip_en = flip;
    sbq.push_back(e);
    wr_cnt = 0;
    rd_cnt = 0;
    d0 = done_cnt_a;
    @(negedge clk);
    start_a = 1'b1;
    invert  = inv;
    @(posedge clk);  // E0
    #1;
    start_a = 1'b0;
    invert  = ~inv;  // must not affect the running test
    cyc = 0;
    got = 1'b0;
    while (cyc < 300 && !got) begin
      @(posedge clk);
      #1;
      cyc++;
      start_a = poke && (cyc == 10 || cyc == 40);
      if (a_done) got = 1'b1;
    end
    start_a = 1'b0;
    chk("done_latency", 32'(cyc), 32'd65);
    repeat (5) @(posedge clk);
    #1;
    chk("writes", 32'(wr_cnt), 32'd32);
    chk("reads", 32'(rd_cnt), 32'd32);
    chk("done_pulses", 32'(done_cnt_a - d0), 32'd1);
    chk("busy_after", 32'(a_busy), 32'd0);
  endtask

  initial begin
    exp_t e;
    int cyc;
    logic got;
    reset_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    invert  = 1'b0;
    flip_en = 1'b0;
    inv_exp = 1'b0;
    wr_cnt  = 0;
    rd_cnt  = 0;
    done_cnt_a = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_pass", 32'(a_pass), 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    chk("rst_faddr", 32'(a_faddr), 32'd0);
    chk("rst_cen", 32'(a_cen), 32'd0);
    chk("rst_wen", 32'(a_wen), 32'd0);
    chk("rst_addr", 32'(a_addr), 32'd0);
    chk("rst_din", a_din, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Plain pattern: mem[a] = a.
    e = '{err: 8'd0, faddr: 8'd0, pass: 1'b1};
    run_a(1'b0, 1'b0, 1'b0, e);
    for (int i = 0; i < 32; i++) chk("mem_plain", mem[i], 32'(i));

    // Inverted pattern.
    run_a(1'b1, 1'b0, 1'b0, e);
    chk("mem5_inv", mem[5], 32'hffff_fffa);

    // Corrupted reads at addresses 3 and 7.
    e = '{err: 8'd2, faddr: 8'd3, pass: 1'b0};
    run_a(1'b0, 1'b1, 1'b0, e);
    flip_en = 1'b0;

    // Saturation: 256 mismatches on DUT b.
    e = '{err: 8'd255, faddr: 8'd0, pass: 1'b0};
    sbq.push_back(e);
    @(negedge clk);
    start_b = 1'b1;
    invert  = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    cyc = 0;
    got = 1'b0;
    while (cyc < 700 && !got) begin
      @(posedge clk);
      #1;
      cyc++;
      if (b_done) got = 1'b1;
    end
    chk("b_done_latency", 32'(cyc), 32'd513);
    repeat (3) @(negedge clk);

    // Reset in the middle of the read pass.
    inv_exp = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    invert  = 1'b0;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (45) @(posedge clk);
    #2;
    chk("mid_cen_before", 32'(a_cen), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_cen", 32'(a_cen), 32'd0);
    chk("mid_rst_busy", 32'(a_busy), 32'd0);
    chk("mid_rst_addr", 32'(a_addr), 32'd0);
    chk("mid_rst_wen", 32'(a_wen), 32'd0);
    chk("mid_rst_err", 32'(a_err), 32'd0);
    wr_cnt = 0;
    rd_cnt = 0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_access", 32'(wr_cnt + rd_cnt), 32'd0);
    e = '{err: 8'd0, faddr: 8'd0, pass: 1'b1};
    run_a(1'b0, 1'b0, 1'b0, e);

    // start pulses while busy must be ignored.
    run_a(1'b1, 1'b0, 1'b1, e);

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
